// File: rtl/mem_access_sequencer_pkg.sv
// rtl/mem_access_sequencer_pkg.sv - op3 codes, RAM opcodes, FSM and capture encodings
package mem_access_sequencer_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_SWAP = 6'b001111;

    localparam logic [5:0] RAM_LD  = 6'b000000;
    localparam logic [5:0] RAM_ST  = 6'b000100;

    localparam int DEF_MEM_BYTES      = 512;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_MFC,
        S_GAP,
        S_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        CAP_NONE,
        CAP_D0,
        CAP_D1
    } cap_sel_t;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// rtl/mem_access_sequencer_if.sv - CU request/response and RAM MAR/MDR handshake bundle
interface mem_access_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata0;
    logic [31:0] resp_rdata1;
    logic        Enable;
    logic [5:0]  OpCode;
    logic [31:0] MAR_Address;
    logic [31:0] MDR_DataIn;
    logic [31:0] MDR_DataOut;
    logic        MFC;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata0, req_wdata1, MDR_DataOut, MFC,
        output req_ready, resp_valid, resp_error, resp_rdata0, resp_rdata1,
               Enable, OpCode, MAR_Address, MDR_DataIn
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata0, req_wdata1, MDR_DataOut, MFC,
        input  req_ready, resp_valid, resp_error, resp_rdata0, resp_rdata1,
               Enable, OpCode, MAR_Address, MDR_DataIn
    );
endinterface

// File: rtl/mem_access_sequencer_decode.sv
// rtl/mem_access_sequencer_decode.sv - combinational op decode into per-beat RAM accesses
module mem_op_decode
    import mem_access_sequencer_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic [5:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic        i_beat,
    output logic        o_legal,
    output logic        o_last_beat,
    output logic [5:0]  o_opcode,
    output logic [31:0] o_beat_addr,
    output logic        o_wsel,
    output cap_sel_t    o_cap
);
    logic        w_known;
    logic        w_pair;
    logic        w_two;
    logic        w_off4;
    logic [32:0] w_end;

    always_comb begin
        w_known  = 1'b1;
        w_pair   = 1'b0;
        w_two    = 1'b0;
        w_off4   = 1'b0;
        o_opcode = i_op;
        o_wsel   = 1'b0;
        o_cap    = CAP_NONE;
        case (i_op)
            OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH: o_cap = CAP_D0;
            OP_ST, OP_STB, OP_STH: o_cap = CAP_NONE;
            OP_LDD: begin
                w_pair   = 1'b1;
                w_two    = 1'b1;
                w_off4   = i_beat;
                o_opcode = RAM_LD;
                o_cap    = i_beat ? CAP_D1 : CAP_D0;
            end
            OP_STD: begin
                w_pair   = 1'b1;
                w_two    = 1'b1;
                w_off4   = i_beat;
                o_opcode = RAM_ST;
                o_wsel   = i_beat;
            end
            OP_SWAP: begin
                w_two    = 1'b1;
                o_opcode = i_beat ? RAM_ST : RAM_LD;
                o_cap    = i_beat ? CAP_NONE : CAP_D0;
            end
            default: w_known = 1'b0;
        endcase

        // Range is judged on the last byte touched by the final beat.
        w_end       = {1'b0, i_addr} + (w_pair ? 33'd7 : 33'd3);
        o_legal     = w_known && (i_addr[1:0] == 2'b00) && !(w_pair && i_addr[2])
                      && (w_end < 33'(MEM_BYTES));
        o_last_beat = !w_two || i_beat;
        o_beat_addr = i_addr + (w_off4 ? 32'd4 : 32'd0);
    end
endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - sequences CU load/store/SWAP requests into MAR/MDR RAM beats
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int MEM_BYTES      = DEF_MEM_BYTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_access_sequencer_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t     r_state;
    logic           r_beat;
    logic [CW-1:0]  r_cnt;
    logic [5:0]     r_op;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata0;
    logic [31:0]    r_wdata1;
    logic           r_req_ready;
    logic           r_resp_valid;
    logic           r_resp_error;
    logic [31:0]    r_rdata0;
    logic [31:0]    r_rdata1;
    logic           r_enable;
    logic [5:0]     r_opcode;
    logic [31:0]    r_mar;
    logic [31:0]    r_mdr;

    logic [5:0]     w_dec_op;
    logic [31:0]    w_dec_addr;
    logic           w_legal;
    logic           w_last;
    logic [5:0]     w_opcode;
    logic [31:0]    w_beat_addr;
    logic           w_wsel;
    cap_sel_t       w_cap;
    logic           w_timeout;

    // Decode the live request while idle so legality is known at the accept edge.
    assign w_dec_op   = (r_state == S_IDLE) ? bus.req_op   : r_op;
    assign w_dec_addr = (r_state == S_IDLE) ? bus.req_addr : r_addr;
    assign w_timeout  = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    mem_op_decode #(.MEM_BYTES(MEM_BYTES)) u_decode (
        .i_op        (w_dec_op),
        .i_addr      (w_dec_addr),
        .i_beat      (r_beat),
        .o_legal     (w_legal),
        .o_last_beat (w_last),
        .o_opcode    (w_opcode),
        .o_beat_addr (w_beat_addr),
        .o_wsel      (w_wsel),
        .o_cap       (w_cap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_beat       <= 1'b0;
            r_cnt        <= '0;
            r_op         <= '0;
            r_addr       <= '0;
            r_wdata0     <= '0;
            r_wdata1     <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_enable     <= 1'b0;
            r_opcode     <= '0;
            r_mar        <= '0;
            r_mdr        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= 1'b0;
                    if (r_req_ready && bus.req_valid) begin
                        r_req_ready  <= 1'b0;
                        r_op         <= bus.req_op;
                        r_addr       <= bus.req_addr;
                        r_wdata0     <= bus.req_wdata0;
                        r_wdata1     <= bus.req_wdata1;
                        r_beat       <= 1'b0;
                        r_cnt        <= '0;
                        r_rdata0     <= '0;
                        r_rdata1     <= '0;
                        r_resp_error <= !w_legal;
                        r_resp_valid <= !w_legal;
                        r_state      <= w_legal ? S_ISSUE : S_DONE;
                    end else begin
                        r_req_ready  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_enable <= 1'b1;
                    r_opcode <= w_opcode;
                    r_mar    <= w_beat_addr;
                    r_mdr    <= w_wsel ? r_wdata1 : r_wdata0;
                    r_cnt    <= '0;
                    r_state  <= S_WAIT_MFC;
                end
                S_WAIT_MFC: begin
                    if (bus.MFC) begin
                        case (w_cap)
                            CAP_D0:  r_rdata0 <= bus.MDR_DataOut;
                            CAP_D1:  r_rdata1 <= bus.MDR_DataOut;
                            default: ;
                        endcase
                        r_enable <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_GAP;
                    end else if (w_timeout) begin
                        r_enable     <= 1'b0;
                        r_resp_error <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    // The RAM re-arms only after it sees Enable low with MFC cleared.
                    if (!bus.MFC) begin
                        r_cnt <= '0;
                        if (w_last) begin
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_beat  <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_resp_error <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_error  = r_resp_error;
    assign bus.resp_rdata0 = r_rdata0;
    assign bus.resp_rdata1 = r_rdata1;
    assign bus.Enable      = r_enable;
    assign bus.OpCode      = r_opcode;
    assign bus.MAR_Address = r_mar;
    assign bus.MDR_DataIn  = r_mdr;
endmodule
